// File: rtl/regfile_sb.sv
// Multi-port integer register file with a per-register pending-write scoreboard.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle writes to the read ports.
module regfile_sb #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = $clog2(NREG),
    parameter int NRD  = 2,
    parameter int NWR  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic [NWR-1:0]      wr_en,
    input  logic [NWR*AW-1:0]   wr_addr,
    input  logic [NWR*XLEN-1:0] wr_data,
    input  logic              iss_en,
    input  logic [AW-1:0]     iss_addr,
    output logic              iss_ok,
    input  logic              flush,
    output logic [AW:0]       busy_cnt
);

    logic [XLEN-1:0] regs_q [1:NREG-1];
    logic [XLEN-1:0] regs_d [1:NREG-1];
    logic [NREG-1:1] busy_q, busy_d;
    logic [AW:0]     busy_cnt_q, busy_cnt_d;

    function automatic logic [AW:0] popcount(input logic [NREG-1:1] v);
        logic [AW:0] c;
        c = '0;
        for (int k = 1; k < NREG; k++) c = c + (AW+1)'(v[k]);
        return c;
    endfunction

    // Next state: writes (highest port last so it wins), clears, then set, then flush.
    always_comb begin
        regs_d = regs_q;
        busy_d = busy_q;
        for (int r = 1; r < NREG; r++) begin
            for (int j = 0; j < NWR; j++) begin
                if (wr_en[j] && wr_addr[j*AW +: AW] == AW'(r)) begin
                    regs_d[r] = wr_data[j*XLEN +: XLEN];
                    busy_d[r] = 1'b0;
                end
            end
            if (iss_en && iss_addr == AW'(r)) busy_d[r] = 1'b1;
        end
        if (flush) busy_d = '0;
        busy_cnt_d = popcount(busy_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 1; r < NREG; r++) regs_q[r] <= '0;
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    assign busy_cnt = busy_cnt_q;

    // Read ports; address 0 and out-of-range addresses never match a stored register.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        for (int i = 0; i < NRD; i++) begin
            for (int r = 1; r < NREG; r++) begin
                if (rd_addr[i*AW +: AW] == AW'(r)) begin
                    rd_data[i*XLEN +: XLEN] = regs_q[r];
                    rd_busy[i]              = busy_q[r];
`ifdef REGFILE_BYPASS_EN
                    for (int j = 0; j < NWR; j++) begin
                        if (wr_en[j] && wr_addr[j*AW +: AW] == AW'(r)) begin
                            rd_data[i*XLEN +: XLEN] = wr_data[j*XLEN +: XLEN];
                            rd_busy[i]              = iss_en && (iss_addr == AW'(r));
                        end
                    end
`endif
                end
            end
        end
    end

    always_comb begin
        iss_ok = 1'b1;
        for (int r = 1; r < NREG; r++) begin
            if (iss_addr == AW'(r)) begin
                iss_ok = ~busy_q[r];
                for (int j = 0; j < NWR; j++) begin
                    if (wr_en[j] && wr_addr[j*AW +: AW] == AW'(r)) iss_ok = 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed vector bench for regfile_sb (default parameters: 32 x 32b, 2R/2W).
module tb_regfile_sb;
    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int AW   = 5;

    logic              clk = 1'b0;
    logic              rst;
    logic [2*AW-1:0]   rd_addr;
    logic [2*XLEN-1:0] rd_data;
    logic [1:0]        rd_busy;
    logic [1:0]        wr_en;
    logic [2*AW-1:0]   wr_addr;
    logic [2*XLEN-1:0] wr_data;
    logic              iss_en;
    logic [AW-1:0]     iss_addr;
    logic              iss_ok;
    logic              flush;
    logic [AW:0]       busy_cnt;

    int checks = 0;
    int errors = 0;

    regfile_sb #(.XLEN(XLEN), .NREG(NREG), .AW(AW), .NRD(2), .NWR(2)) dut (
        .clk(clk), .rst(rst),
        .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .iss_en(iss_en), .iss_addr(iss_addr), .iss_ok(iss_ok),
        .flush(flush), .busy_cnt(busy_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]      we;
        logic [AW-1:0]   wa0;
        logic [XLEN-1:0] wd0;
        logic [AW-1:0]   wa1;
        logic [XLEN-1:0] wd1;
        logic            ie;
        logic [AW-1:0]   ia;
        logic            fl;
        logic            rs;
        logic [AW-1:0]   ra0;
        logic [AW-1:0]   ra1;
        logic [XLEN-1:0] ed0;
        logic            eb0;
        logic [XLEN-1:0] ed1;
        logic            eb1;
        logic [AW:0]     ecnt;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle();
        wr_en = '0; wr_addr = '0; wr_data = '0;
        iss_en = 1'b0; iss_addr = '0; flush = 1'b0; rst = 1'b0;
    endtask

    task automatic set_wr(input logic [1:0] we, input logic [AW-1:0] a0, input logic [XLEN-1:0] d0,
                          input logic [AW-1:0] a1, input logic [XLEN-1:0] d1);
        wr_en = we; wr_addr = {a1, a0}; wr_data = {d1, d0};
    endtask

    initial begin
        idle();
        rd_addr = '0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        rd_addr = {AW'(7), AW'(5)};
        #1;
        check("reset rd_data", 64'(rd_data[XLEN-1:0]), 64'h0);
        check("reset rd_busy", 64'(rd_busy), 64'h0);
        check("reset busy_cnt", 64'(busy_cnt), 64'h0);
        check("reset iss_ok", 64'(iss_ok), 64'h1);

        //            we     wa0 wd0           wa1 wd1    ie ia fl rs ra0 ra1 ed0           eb0 ed1    eb1 cnt
        vecs[0]  = '{2'b01, 5,  32'hDEADBEEF, 0,  0,     1, 7, 0, 0, 5,  7,  32'hDEADBEEF, 0,  0,     1,  1};
        vecs[1]  = '{2'b01, 5,  32'h1,        0,  0,     1, 8, 0, 1, 5,  8,  0,            0,  0,     0,  0};
        vecs[2]  = '{2'b01, 0,  32'hFFFFFFFF, 0,  0,     1, 0, 0, 0, 0,  0,  0,            0,  0,     0,  0};
        vecs[3]  = '{2'b11, 3,  32'h11,       3,  32'h22,0, 0, 0, 0, 3,  5,  32'h22,       0,  0,     0,  0};
        vecs[4]  = '{2'b00, 0,  0,            0,  0,     1, 4, 0, 0, 4,  3,  0,            1,  32'h22,0,  1};
        vecs[5]  = '{2'b01, 4,  32'h5,        0,  0,     1, 4, 0, 0, 4,  3,  32'h5,        1,  32'h22,0,  1};
        vecs[6]  = '{2'b10, 0,  0,            4,  32'h7, 0, 0, 0, 0, 4,  0,  32'h7,        0,  0,     0,  0};
        vecs[7]  = '{2'b00, 0,  0,            0,  0,     1, 1, 0, 0, 1,  2,  0,            1,  0,     0,  1};
        vecs[8]  = '{2'b00, 0,  0,            0,  0,     1, 2, 0, 0, 1,  2,  0,            1,  0,     1,  2};
        vecs[9]  = '{2'b00, 0,  0,            0,  0,     1, 3, 0, 0, 3,  1,  32'h22,       1,  0,     1,  3};
        vecs[10] = '{2'b01, 10, 32'hAB,       0,  0,     1, 9, 1, 0, 9,  10, 0,            0,  32'hAB,0,  0};
        vecs[11] = '{2'b11, 0,  32'h55,       11, 32'h66,1, 11,0, 0, 11, 1,  32'h66,       1,  0,     0,  1};

        for (int v = 0; v < 12; v++) begin
            set_wr(vecs[v].we, vecs[v].wa0, vecs[v].wd0, vecs[v].wa1, vecs[v].wd1);
            iss_en = vecs[v].ie; iss_addr = vecs[v].ia;
            flush = vecs[v].fl; rst = vecs[v].rs;
            @(posedge clk); #1;
            idle();
            rd_addr = {vecs[v].ra1, vecs[v].ra0};
            #1;
            check($sformatf("v%0d rd_data0", v), 64'(rd_data[XLEN-1:0]), 64'(vecs[v].ed0));
            check($sformatf("v%0d rd_busy0", v), 64'(rd_busy[0]), 64'(vecs[v].eb0));
            check($sformatf("v%0d rd_data1", v), 64'(rd_data[2*XLEN-1:XLEN]), 64'(vecs[v].ed1));
            check($sformatf("v%0d rd_busy1", v), 64'(rd_busy[1]), 64'(vecs[v].eb1));
            check($sformatf("v%0d busy_cnt", v), 64'(busy_cnt), 64'(vecs[v].ecnt));
        end

        // iss_ok: x11 is busy here.
        iss_addr = 5'd11; #1;
        check("iss_ok busy", 64'(iss_ok), 64'h0);
        set_wr(2'b01, 5'd11, 32'h0, 5'd0, 32'h0); #1;
        check("iss_ok same-cycle clear", 64'(iss_ok), 64'h1);
        idle(); iss_addr = 5'd0; #1;
        check("iss_ok x0", 64'(iss_ok), 64'h1);
        iss_addr = 5'd3; #1;
        check("iss_ok free", 64'(iss_ok), 64'h1);

        // Same-cycle write then read of x6 (old 0) and x11 (old 0x66, busy).
        idle();
        set_wr(2'b11, 5'd6, 32'hCAFE, 5'd11, 32'h77);
        rd_addr = {AW'(11), AW'(6)};
        #1;
`ifdef REGFILE_BYPASS_EN
        check("bypass rd_data x6", 64'(rd_data[XLEN-1:0]), 64'hCAFE);
        check("bypass rd_data x11", 64'(rd_data[2*XLEN-1:XLEN]), 64'h77);
        check("bypass rd_busy x11", 64'(rd_busy[1]), 64'h0);
`else
        check("nobypass rd_data x6", 64'(rd_data[XLEN-1:0]), 64'h0);
        check("nobypass rd_data x11", 64'(rd_data[2*XLEN-1:XLEN]), 64'h66);
        check("nobypass rd_busy x11", 64'(rd_busy[1]), 64'h1);
`endif
        @(posedge clk); #1;
        idle(); #1;
        check("post-write x6", 64'(rd_data[XLEN-1:0]), 64'hCAFE);
        check("post-write x11", 64'(rd_data[2*XLEN-1:XLEN]), 64'h77);
        check("post-write busy_cnt", 64'(busy_cnt), 64'h0);

        // Mid-operation reset discards in-flight marks and contents.
        iss_en = 1'b1; iss_addr = 5'd13;
        @(posedge clk); #1;
        idle(); rd_addr = {AW'(13), AW'(6)}; #1;
        check("pre-rst busy_cnt", 64'(busy_cnt), 64'h1);
        rst = 1'b1; iss_en = 1'b1; iss_addr = 5'd14;
        @(posedge clk); #1;
        idle(); #1;
        check("rst busy_cnt", 64'(busy_cnt), 64'h0);
        check("rst rd_busy x13", 64'(rd_busy[1]), 64'h0);
        check("rst rd_data x6", 64'(rd_data[XLEN-1:0]), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
